opt_pass_scheduler: RTL
=======================

Name: opt_pass_scheduler

Overview:
- Arbitrates Or-opt route-rewrite requests from NREQ replica requesters onto the shared 8-city-per-word route streaming datapath.
- Sequences one full route pass per granted request: issues the one-cycle command pulse, holds the opt descriptor stable, produces the one-cycle-delayed copies the datapath consumes, then reports completion.
- Sits between the replica exchange/annealing control and the route-rewrite datapath.

Parameters:
- CITY_NUM, 32, cities per route; must be a multiple of 8 and at most 128.
- NREQ, 4, number of requesters; must be at least 2.
- DRAIN_CYC, 2, idle cycles after the last stream beat before done is reported.
- Derived: WORDS = CITY_NUM/8; IDW = clog2(NREQ).

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester request pending.
- req_cmd  in  NREQ*2  per-requester opcode: 0=NOP, 1=THR, 2=OR0, 3=OR1.
- req_k  in  NREQ*7  per-requester K (segment source index).
- req_l  in  NREQ*7  per-requester L (insertion index).
- req_ready  out  NREQ  one-hot grant; request accepted when valid&ready.
- command  out  2  datapath command; non-NOP for exactly one cycle per pass.
- opt_cmd, opt_k, opt_l  out  2/7/7  descriptor for the current pass.
- opt_d_cmd, opt_d_k, opt_d_l  out  2/7/7  opt registered by one cycle.
- command_nop_d  out  1  registered (command == NOP).
- busy  out  1  state != IDLE.
- done_valid  out  1  one-cycle completion pulse.
- done_id  out  IDW  requester index of the completed pass.
- err  out  1  one-cycle pulse on the ISSUE cycle if the request was invalid.

Behaviour:
- Reset values: req_ready=0, command=NOP, opt_*=0, opt_d_*=0, command_nop_d=1, busy=0, done_valid=0, done_id=0, err=0, rr pointer=0, state=IDLE.
- Reset taken mid-pass aborts the pass; no done_valid is produced; the datapath sees NOP from the next cycle.
- States: IDLE, ISSUE, INIT, STREAM, DRAIN.
- IDLE:
  - req_ready is combinational. Round-robin selection starts at the rr pointer; the first valid index gets req_ready=1.
  - On a grant: latch cmd/K/L and the id, set rr pointer = id+1 mod NREQ, go to ISSUE.
  - A granted NOP is latched as THR.
- Validation, done at latch time:
  - OR0 requires K < L < CITY_NUM.
  - OR1 requires L < K < CITY_NUM.
  - An invalid request is executed as THR and err is pulsed in ISSUE.
- ISSUE (1 cycle): command = latched cmd and opt_* = latched values. Next state is INIT if the cmd is OR1, otherwise STREAM with beat=0.
- INIT (OR1 only, 1 cycle): command = NOP. Next state is STREAM with beat=0.
- STREAM (WORDS cycles): command = NOP; beat increments each cycle. When beat == WORDS-1, go to DRAIN.
- DRAIN (DRAIN_CYC cycles): done_valid=1 and done_id=latched id in the last DRAIN cycle, then go to IDLE.
- opt_* hold their value from ISSUE until the next ISSUE; they do not clear at done.
- opt_d_* <= opt_* every cycle. command_nop_d <= (command==NOP) every cycle.
- req_ready is 0 in every state other than IDLE, so there is at most one grant per pass. A new grant is possible in the cycle after done_valid.
- Latency from grant cycle G:
  - command at G+1.
  - done_valid at G+1+WORDS+DRAIN_CYC for THR/OR0.
  - done_valid one cycle later for OR1.
- Requesters must hold req_valid and payload stable until granted. Dropping valid before the grant is legal, and the request is simply not granted.
- Simultaneous requests: strict round-robin. No requester is starved for more than NREQ-1 passes.

Test Plan:
- CITY_NUM=32, DRAIN_CYC=2, single THR on req 0 granted at cycle 0 -> command=1 at cycle 1; command_nop_d=0 at cycle 2; busy 1..7; done_valid with done_id=0 at cycle 7; IDLE at cycle 8.
- OR1 with K=20, L=5 on req 2 -> command=3 for one cycle; INIT cycle; done_valid 1 cycle later than THR (cycle 8); opt_d_k=20 one cycle after opt_k=20.
- All 4 requesters valid continuously, rr pointer starts at 0 -> grants in order 0,1,2,3,0; each grant lands in the cycle after the previous done_valid.
- OR0 with K=10, L=3 (invalid) -> err pulse on the ISSUE cycle; command=1 (THR); normal THR timing; done_valid still issued.
- Reset asserted on the 2nd STREAM beat -> the next cycle shows command=NOP, busy=0, command_nop_d=1; no done_valid; rr pointer=0.
- Requester drops req_valid while another pass is busy -> no grant for it; the next valid requester in rr order is granted.

Source files
------------

// File: rtl/opt_pass_scheduler.sv
// Round-robin scheduler for Or-opt route passes: one grant per pass, command at grant+1, done at grant+1+WORDS+DRAIN_CYC (+1 for OR1).
// Backpressure: req_ready is offered only in IDLE, so requesters hold their request until the scheduler is free.
module opt_pass_scheduler #(
  parameter int CITY_NUM  = 32,
  parameter int NREQ      = 4,
  parameter int DRAIN_CYC = 2,
  localparam int WORDS    = CITY_NUM / 8,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*2-1:0]  req_cmd,
  input  logic [NREQ*7-1:0]  req_k,
  input  logic [NREQ*7-1:0]  req_l,
  output logic [NREQ-1:0]    req_ready,
  output logic [1:0]         command,
  output logic [1:0]         opt_cmd,
  output logic [6:0]         opt_k,
  output logic [6:0]         opt_l,
  output logic [1:0]         opt_d_cmd,
  output logic [6:0]         opt_d_k,
  output logic [6:0]         opt_d_l,
  output logic               command_nop_d,
  output logic               busy,
  output logic               done_valid,
  output logic [IDW-1:0]     done_id,
  output logic               err
);

  localparam logic [1:0] CMD_NOP = 2'd0;
  localparam logic [1:0] CMD_THR = 2'd1;
  localparam logic [1:0] CMD_OR0 = 2'd2;
  localparam logic [1:0] CMD_OR1 = 2'd3;
  localparam int CNT_MAX = (WORDS > DRAIN_CYC) ? WORDS : DRAIN_CYC;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_INIT, S_STREAM, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IDW-1:0]  r_rr, r_id;
  logic            r_err;
  logic [1:0]      r_opt_cmd, r_opt_d_cmd;
  logic [6:0]      r_opt_k, r_opt_l, r_opt_d_k, r_opt_d_l;
  logic            r_nop_d;

  logic [NREQ-1:0] w_rot;
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_off, w_gnt_id, w_rr_nxt;
  logic [IDW:0]    w_sum;
  logic [1:0]      w_cmd_a [NREQ];
  logic [6:0]      w_k_a   [NREQ];
  logic [6:0]      w_l_a   [NREQ];
  logic [1:0]      w_sel_cmd, w_lat_cmd;
  logic [6:0]      w_sel_k, w_sel_l;
  logic            w_lat_err, w_grant;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_cmd_a[i] = req_cmd[i*2 +: 2];
      w_k_a[i]   = req_k[i*7 +: 7];
      w_l_a[i]   = req_l[i*7 +: 7];
    end
  end

  // Rotate so bit 0 is the rr pointer; first set bit is the winner.
  always_comb begin
    w_rot     = NREQ'({req_valid, req_valid} >> r_rr);
    w_gnt_vld = 1'b0;
    w_off     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_vld && w_rot[i]) begin
        w_gnt_vld = 1'b1;
        w_off     = IDW'(i);
      end
    end
    w_sum    = {1'b0, r_rr} + {1'b0, w_off};
    w_gnt_id = (w_sum >= (IDW+1)'(NREQ)) ? IDW'(w_sum - (IDW+1)'(NREQ)) : IDW'(w_sum);
    w_rr_nxt = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
    w_grant  = (r_state == S_IDLE) && w_gnt_vld;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_grant && (w_gnt_id == IDW'(i));
    end
  end

  // Malformed Or-opt requests degrade to a plain pass rather than stall the requester.
  always_comb begin
    w_sel_cmd = w_cmd_a[w_gnt_id];
    w_sel_k   = w_k_a[w_gnt_id];
    w_sel_l   = w_l_a[w_gnt_id];
    w_lat_cmd = CMD_THR;
    w_lat_err = 1'b0;
    case (w_sel_cmd)
      CMD_OR0: begin
        if ((w_sel_k < w_sel_l) && ({1'b0, w_sel_l} < 8'(CITY_NUM))) w_lat_cmd = CMD_OR0;
        else w_lat_err = 1'b1;
      end
      CMD_OR1: begin
        if ((w_sel_l < w_sel_k) && ({1'b0, w_sel_k} < 8'(CITY_NUM))) w_lat_cmd = CMD_OR1;
        else w_lat_err = 1'b1;
      end
      default: w_lat_cmd = CMD_THR;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    command     = CMD_NOP;
    err         = 1'b0;
    done_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        command     = r_opt_cmd;
        err         = r_err;
        w_cnt_nxt   = '0;
        w_state_nxt = (r_opt_cmd == CMD_OR1) ? S_INIT : S_STREAM;
      end
      S_INIT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (r_cnt == CW'(WORDS-1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (r_cnt == CW'(DRAIN_CYC-1)) begin
          done_valid  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr        <= '0;
      r_id        <= '0;
      r_err       <= 1'b0;
      r_opt_cmd   <= '0;
      r_opt_k     <= '0;
      r_opt_l     <= '0;
      r_opt_d_cmd <= '0;
      r_opt_d_k   <= '0;
      r_opt_d_l   <= '0;
      r_nop_d     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_opt_d_cmd <= r_opt_cmd;
      r_opt_d_k   <= r_opt_k;
      r_opt_d_l   <= r_opt_l;
      r_nop_d     <= (command == CMD_NOP);
      if (w_grant) begin
        r_id      <= w_gnt_id;
        r_rr      <= w_rr_nxt;
        r_err     <= w_lat_err;
        r_opt_cmd <= w_lat_cmd;
        r_opt_k   <= w_sel_k;
        r_opt_l   <= w_sel_l;
      end
    end
  end

  assign opt_cmd       = r_opt_cmd;
  assign opt_k         = r_opt_k;
  assign opt_l         = r_opt_l;
  assign opt_d_cmd     = r_opt_d_cmd;
  assign opt_d_k       = r_opt_d_k;
  assign opt_d_l       = r_opt_d_l;
  assign command_nop_d = r_nop_d;
  assign busy          = (r_state != S_IDLE);
  assign done_id       = r_id;

endmodule
